// File: rtl/quicksort_seq.sv
// quicksort_seq: streams one batch into a toggle-command sorter, sorts it, and drains it largest-first.
// Commands are single flips of the q_* lines, each followed by a guarded WAIT on the sorter's idle.
module quicksort_seq #(
    parameter int D_W   = 8,
    parameter int CAP   = 255,
    parameter int CNT_W = 16
) (
    input  logic             clk1,
    input  logic             rstn,
    input  logic             enable,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [D_W-1:0]   s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [D_W-1:0]   m_data,
    output logic             m_last,
    output logic             busy,
    output logic             err_ovf,
    output logic             err_abort,
    output logic [CNT_W-1:0] sort_cycles,
    output logic             q_enable,
    output logic             q_push,
    output logic             q_pop,
    output logic             q_clear,
    output logic             q_sort,
    output logic [D_W-1:0]   q_rx_data,
    input  logic [D_W-1:0]   q_tx_data,
    input  logic             q_idle
);
    localparam int C_W = $clog2(CAP + 1);
    typedef enum logic [2:0] {IDLE, CLR, LOAD, SORT, POP, OUT, WAIT} state_t;
    state_t state, state_nx, succ;
    logic [1:0] guard;
    logic [C_W-1:0] count;
    logic [CNT_W-1:0] cyc, cyc_inc;
    logic dirty, go, do_clr, do_push, do_sort, do_pop, wait_done, full;

    always_ff @(posedge clk1 or negedge rstn)
        if (!rstn) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        if (!go) state_nx = IDLE;
        else
            unique case (state)
                IDLE:    state_nx = s_valid && enable ? CLR : IDLE;
                LOAD:    state_nx = do_push ? WAIT : LOAD;
                WAIT:    state_nx = wait_done ? succ : WAIT;
                OUT:     state_nx = m_valid && m_ready ? (count == '0 ? IDLE : POP) : OUT;
                default: state_nx = WAIT;
            endcase
    end

    // Dropping enable outside IDLE aborts: no command may fire on that edge.
    always_comb begin
        go = enable || state == IDLE;
        do_clr = go && state == CLR;
        do_push = go && state == LOAD && s_valid && s_ready;
        do_sort = go && state == SORT;
        do_pop = go && state == POP;
        wait_done = go && state == WAIT && guard == 2'd0 && q_idle;
        full = count == C_W'(CAP - 1);
        cyc_inc = &cyc ? cyc : cyc + 1'b1;
    end

    assign busy = state != IDLE;

    always_ff @(posedge clk1 or negedge rstn)
        if (!rstn) begin
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            m_last <= 1'b0;
            m_data <= '0;
            err_ovf <= 1'b0;
            err_abort <= 1'b0;
            sort_cycles <= '0;
            q_enable <= 1'b0;
            q_push <= 1'b0;
            q_pop <= 1'b0;
            q_clear <= 1'b0;
            q_sort <= 1'b0;
            q_rx_data <= '0;
            succ <= IDLE;
            guard <= 2'd0;
            count <= '0;
            cyc <= '0;
            dirty <= 1'b0;
        end else begin
            q_enable <= enable;
            s_ready <= state_nx == LOAD;
            m_valid <= state_nx == OUT;
            m_last <= state_nx == OUT && count == '0;
            q_clear <= q_clear ^ do_clr;
            q_push <= q_push ^ do_push;
            q_sort <= q_sort ^ do_sort;
            q_pop <= q_pop ^ do_pop;
            if (do_clr || do_push || do_sort || do_pop) guard <= 2'd2;
            else if (guard != 2'd0) guard <= guard - 2'd1;
            if (state == IDLE && state_nx == CLR) begin
                err_ovf <= 1'b0;
                err_abort <= 1'b0;
            end
            if (!go) begin
                err_abort <= 1'b1;
                dirty <= 1'b1;
                count <= '0;
            end
            if (do_clr) begin
                succ <= dirty ? CLR : LOAD;
                dirty <= 1'b0;
            end
            if (do_push) begin
                q_rx_data <= s_data;
                count <= count + 1'b1;
                succ <= s_last || full ? SORT : LOAD;
                if (full && !s_last) err_ovf <= 1'b1;
            end
            if (do_sort) begin
                succ <= POP;
                cyc <= '0;
            end else if (state == WAIT && succ == POP) cyc <= cyc_inc;
            if (wait_done && succ == POP) sort_cycles <= cyc_inc;
            if (do_pop) begin
                succ <= OUT;
                count <= count - 1'b1;
            end
            if (wait_done && succ == OUT) m_data <= q_tx_data;
        end
endmodule
